// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter and sequencer for the single-port main memory
//
// Purpose:
//   Requester 0 (data-cache miss/write-back) and requester 1 (instruction
//   fetch) share one single-port memory. One requester is granted at a time.
//   The arbiter holds the address, strobe and write data for MEM_LAT cycles,
//   captures read data on the last access cycle, and then pulses done for
//   one cycle.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  memory access cycles per transaction (1..15)
//
// Ports:
//   clk                   system clock, rising edge
//   clr                   asynchronous active-low reset
//   req0/wr0/addr0/wdata0 requester 0 request, op (1=write), address, write data
//   gnt0/done0/rdata0     requester 0 grant, completion pulse, read data
//   req1/wr1/addr1/wdata1 requester 1 request, op (1=write), address, write data
//   gnt1/done1/rdata1     requester 1 grant, completion pulse, read data
//   mem_addr/mem_rd/mem_wr/mem_dout  memory address, strobes, write data
//   mem_din               memory read data
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins ties and the
//                          round-robin pointer is removed.

module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       win;    // requester currently owning the memory
  logic       pick1;  // requester 1 wins the arbitration this cycle
  logic       sel_wr;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Requester 0 always has precedence; 1 only wins when 0 is idle.
  assign pick1 = req1 && !req0;
`else
  logic last;  // requester served most recently
  // On a tie, the requester that was not served last wins.
  assign pick1 = req1 && (!req0 || !last);
`endif

  assign sel_wr = pick1 ? wr1 : wr0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      win      <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_dout <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            win      <= pick1;
            gnt0     <= !pick1;
            gnt1     <= pick1;
            mem_addr <= pick1 ? addr1 : addr0;
            mem_dout <= pick1 ? wdata1 : wdata0;
            mem_wr   <= sel_wr;
            mem_rd   <= !sel_wr;
            cnt      <= CNT_INIT;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          if (cnt == 4'd0) begin
            // Last access cycle: mem_din is valid for a read now.
            if (mem_rd) begin
              if (win) rdata1 <= mem_din;
              else     rdata0 <= mem_din;
            end
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            done0  <= !win;
            done1  <= win;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last  <= win;
`endif
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port MANO main memory.
- Requester 0 is the data-cache miss/write-back path; requester 1 is the instruction-fetch path.
- Grants one requester at a time and drives mem_addr/mem_rd/mem_wr/mem_dout for a fixed number of memory cycles.
- Captures read data, then returns it to the winner with a one-cycle done pulse.

Parameters:
- ADDR_W, 12, address width (matches `addrwidth).
- DATA_W, 16, data width (matches `datawidth).
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset; asynchronous, active-low.
- req0  in  1  requester 0 request; level, held until done0.
- wr0  in  1  requester 0 op: 1 = write, 0 = read; stable while req0.
- addr0  in  ADDR_W  requester 0 address; stable while req0.
- wdata0  in  DATA_W  requester 0 write data.
- gnt0  out  1  requester 0 owns memory.
- done0  out  1  one-cycle completion pulse, requester 0.
- rdata0  out  DATA_W  read data for requester 0; valid while done0 = 1, held until next requester-0 read completes.
- req1, wr1, addr1, wdata1, gnt1, done1, rdata1: same definitions for requester 1.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_dout  out  DATA_W  write data to memory.
- mem_din  in  DATA_W  read data from memory.

Behaviour:
- Reset values (clr low, asynchronous):
  - State IDLE.
  - gnt0, gnt1, done0, done1, mem_rd, mem_wr = 0.
  - mem_addr, mem_dout, rdata0, rdata1 = 0.
  - Counter = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- IDLE: gnt, done and strobes are all 0. At a clock edge with any req high:
  - Select a winner.
  - Latch its addr, wr and wdata into mem_addr, mem_wr/mem_rd and mem_dout.
  - Set gnt for the winner, counter = MEM_LAT-1, go to ACCESS.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last wins (round-robin).
- ACCESS:
  - Exactly one of mem_rd/mem_wr is high; mem_addr and mem_dout are stable.
  - Each edge decrements the counter.
  - At the edge where counter == 0: on a read, capture mem_din into the winner's rdata. Then drop strobes, go to DONE.
- DONE:
  - Winner's done = 1 for exactly one cycle; gnt is still high.
  - Next edge: gnt = 0, last = winner, go to IDLE.
- Latency: req sampled at edge k → strobes high for cycles k+1 .. k+MEM_LAT → done in cycle k+MEM_LAT+1.
- Handshake:
  - The requester deasserts req at the edge that ends its done cycle.
  - A req still high when sampled in IDLE is a new transaction.
  - Minimum spacing between transactions is one IDLE cycle.
- Requester inputs are sampled only in IDLE. Changes to req/addr/wr/wdata during ACCESS or DONE are ignored.
- Req dropped mid-transaction: the transaction still completes and done still pulses.
- Simultaneous events:
  - A loser's req held during another's transaction is served in the next IDLE.
  - Alternating service is guaranteed when both requesters are continuously requesting.
- Reset mid-ACCESS: strobes drop immediately, the transaction is discarded, and no done is issued.
- Invariants:
  - gnt0 and gnt1 are never both 1.
  - mem_rd and mem_wr are never both 1.
  - Strobes are 0 outside ACCESS.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins ties; last is neither updated nor used. This guarantees write-back/miss traffic precedence over fetch.
- Undefined: round-robin as above.

Test Plan:
- Single read, MEM_LAT=2:
  - Stimulus: req1 = 1, wr1 = 0, addr1 = 12'h0A5; memory returns 16'h1234.
  - Response: gnt1 one edge later; mem_rd high 2 cycles with mem_addr = 0A5; done1 in the 3rd cycle after the sampling edge; rdata1 = 1234.
- Single write:
  - Stimulus: req0 = 1, wr0 = 1, addr0 = 12'hF00, wdata0 = 16'hBEEF.
  - Response: mem_wr high 2 cycles, mem_addr = F00, mem_dout = BEEF; mem_rd stays 0; done0 pulses once.
- Tie after reset:
  - Stimulus: req0 and req1 rise together and are held until done.
  - Response: served in order 0, 1, 0, 1 with one IDLE cycle between each; gnt0/gnt1 never overlap.
- Fixed-priority build:
  - Stimulus: MEM_ARB_FIXED_PRIO_EN defined; req0 and req1 held high continuously.
  - Response: requester 0 served every transaction; requester 1 is never granted until req0 drops.
- Reset mid-access:
  - Stimulus: clr driven low during the first ACCESS cycle of a write.
  - Response: mem_wr = 0 immediately, no done pulse, all outputs at reset values; a new request after clr rises completes normally.
- MEM_LAT=1 boundary:
  - Stimulus: a read to address 12'h001.
  - Response: mem_rd high exactly one cycle; done in the 2nd cycle after the sampling edge; rdata holds the captured mem_din.
